// File: rtl/prog_counter.sv
// Programmable up/down modulo counter with IDLE/RUN/DONE control, one-shot or free-run.
// Define PROG_COUNTER_PRESCALE_EN to add the prescale port and tick divider.
module prog_counter #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic             one_shot,
   input  logic [WIDTH-1:0] limit,
   input  logic             oe,
`ifdef PROG_COUNTER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale,
`endif
   output logic [WIDTH-1:0] count_out,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   if (WIDTH < 2 || PRESCALE_W < 1) begin : g_bad_cfg
      $error("prog_counter: WIDTH must be >= 2 and PRESCALE_W >= 1");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, busy_q, done_q;
   logic             div_hit;
   logic             tick;
   logic             term;

`ifdef PROG_COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic                  div_clr;

   // The divider restarts on anything that repositions the count or the run phase.
   assign div_clr = load | stop | (start & (state_q != ST_RUN));
   assign div_hit = (div_q == prescale);

   always_comb begin
      div_d = div_q;
      if (div_clr)
         div_d = '0;
      else if (state_q == ST_RUN)
         div_d = div_hit ? '0 : div_q + PRESCALE_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_q <= '0;
      else
         div_q <= div_d;
   end
`else
   assign div_hit = 1'b1;
`endif

   assign tick = (state_q == ST_RUN) & ~load & div_hit;
   assign term = dir ? (cnt_q == limit) : (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (tick) begin
         if (term) begin
            if (!one_shot)
               cnt_d = dir ? '0 : limit;
         end else begin
            cnt_d = dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (stop)
               state_d = ST_IDLE;
            else if (tick && term && one_shot)
               state_d = ST_DONE;
         end
         ST_IDLE, ST_DONE: begin
            if (start && !stop)
               state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tick & term;
         busy_q  <= (state_d == ST_RUN);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign count_out = oe ? cnt_q : '0;
   assign tc        = tc_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed plus random stimulus for prog_counter, checked against a cycle-level rule model.
module tb_prog_counter;
   localparam int W = 8;
   localparam int M = 256;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b1, one_shot = 1'b0, oe = 1'b1;
   logic [W-1:0] load_val = '0, limit = '0;
   logic [W-1:0] count_out;
   logic         tc, busy, done;
`ifdef PROG_COUNTER_PRESCALE_EN
   logic [3:0]   prescale = '0;
`endif

   prog_counter #(.WIDTH(W), .PRESCALE_W(4)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .dir(dir), .one_shot(one_shot),
      .limit(limit), .oe(oe),
`ifdef PROG_COUNTER_PRESCALE_EN
      .prescale(prescale),
`endif
      .count_out(count_out), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state: count value, mode (0 idle, 1 run, 2 done), last tc.
   int m_cnt = 0;
   int m_state = 0;
   bit m_tc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count_out"}, 32'(count_out), oe ? 32'(m_cnt) : 32'd0);
      check({tag, ".tc"}, 32'(tc), 32'(m_tc));
      check({tag, ".busy"}, 32'(busy), 32'(m_state == 1));
      check({tag, ".done"}, 32'(done), 32'(m_state == 2));
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_state = 0;
      m_tc = 0;
   endtask

   // One clock: apply inputs, predict from the rules, compare after the edge.
   task automatic step(input string tag, input bit ld, input int lv, input bit st, input bit sp,
                       input bit d, input bit os, input int lim, input bit o);
      int nc, ns;
      bit tk, term;
      @(negedge clk);
      load = ld; load_val = W'(lv); start = st; stop = sp;
      dir = d; one_shot = os; limit = W'(lim); oe = o;
      tk   = (m_state == 1) && !ld;
      term = d ? (m_cnt == lim) : (m_cnt == 0);
      if (ld)
         nc = lv;
      else if (tk && term)
         nc = os ? m_cnt : (d ? 0 : lim);
      else if (tk)
         nc = d ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
      else
         nc = m_cnt;
      ns = m_state;
      if (m_state == 1) begin
         if (sp) ns = 0;
         else if (tk && term && os) ns = 2;
      end else if (st && !sp) begin
         ns = 1;
      end
      @(posedge clk);
      #1;
      m_cnt = nc;
      m_state = ns;
      m_tc = tk && term;
      check_all(tag);
   endtask

   initial begin
      int exp1[7];
      int exp4[8];
      bit r_dir, r_os, r_oe;
      int r_lim;
      exp1 = '{1, 2, 3, 4, 5, 0, 1};
      exp4 = '{255, 0, 1, 2, 3, 4, 5, 0};

      // Reset state
      #2;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Free-run up count, limit 5
      step("t1.start", 0, 0, 1, 0, 1, 0, 5, 1);
      check("t1.busy_after_start", 32'(busy), 32'd1);
      check("t1.cnt_after_start", 32'(count_out), 32'd0);
      for (int i = 0; i < 7; i++) begin
         step("t1.run", 0, 0, 0, 0, 1, 0, 5, 1);
         check($sformatf("t1.cnt%0d", i), 32'(count_out), 32'(exp1[i]));
         check($sformatf("t1.tc%0d", i), 32'(tc), 32'(i == 5));
      end
      step("t1.stop", 0, 0, 0, 1, 1, 0, 5, 1);
      check("t1.idle_after_stop", 32'(busy), 32'd0);

      // One-shot down count from a load+start
      step("t2.loadstart", 1, 3, 1, 0, 0, 1, 5, 1);
      check("t2.loaded", 32'(count_out), 32'd3);
      for (int i = 0; i < 3; i++) begin
         step("t2.run", 0, 0, 0, 0, 0, 1, 5, 1);
         check($sformatf("t2.cnt%0d", i), 32'(count_out), 32'(2 - i));
      end
      step("t2.term", 0, 0, 0, 0, 0, 1, 5, 1);
      check("t2.done", 32'(done), 32'd1);
      check("t2.tc_pulse", 32'(tc), 32'd1);
      check("t2.hold0", 32'(count_out), 32'd0);
      step("t2.hold", 0, 0, 0, 0, 0, 1, 5, 1);
      check("t2.tc_single", 32'(tc), 32'd0);
      check("t2.not_busy", 32'(busy), 32'd0);

      // Load mid-run overrides the increment; stop beats start
      step("t3.loadstart", 1, 16, 1, 0, 1, 0, 255, 1);
      step("t3.load80", 1, 128, 0, 0, 1, 0, 255, 1);
      check("t3.cnt80", 32'(count_out), 32'h80);
      step("t3.startstop", 0, 0, 1, 1, 1, 0, 255, 1);
      check("t3.idle", 32'(busy), 32'd0);

      // Count above limit wraps through all-ones silently
      step("t4.loadstart", 1, 254, 1, 0, 1, 0, 5, 1);
      for (int i = 0; i < 8; i++) begin
         step("t4.run", 0, 0, 0, 0, 1, 0, 5, 1);
         check($sformatf("t4.cnt%0d", i), 32'(count_out), 32'(exp4[i]));
         check($sformatf("t4.tc%0d", i), 32'(tc), 32'(i == 7));
      end

      // Output gating, then asynchronous reset mid-run
      for (int i = 0; i < 4; i++)
         step("t5.oe0", 0, 0, 0, 0, 1, 0, 9, 0);
      @(negedge clk);
      oe = 1'b1;
      #1;
      check("t5.oe_same_cycle", 32'(count_out), 32'(m_cnt));
      rst = 1'b1;
      #1;
      model_reset();
      check_all("t5.async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Random traffic
      r_dir = 1; r_os = 0; r_oe = 1; r_lim = 7;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(31) == 0) r_dir = ~r_dir;
         if ($urandom_range(49) == 0) r_os = ~r_os;
         if ($urandom_range(39) == 0)
            r_lim = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(15));
         r_oe = ($urandom_range(9) != 0);
         step("rand", $urandom_range(15) == 0, int'($urandom_range(255)),
              $urandom_range(3) == 0, $urandom_range(19) == 0, r_dir, r_os, r_lim, r_oe);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
